// File: rtl/ps2_mouse_device_tx.sv
// Device-side PS/2 mouse: drives the PS/2 clock and streams 3-byte packets until the host position matches the target.
// Optional build macro PS2_DEV_RATE_LIMIT_EN enforces a minimum LOAD-to-LOAD spacing of SAMPLE_CYCLES.
module ps2_mouse_device_tx #(
   parameter int HALF_BIT_CYCLES = 2000,
   parameter int IDLE_CYCLES     = 2500,
   parameter int MAX_X           = 1023,
   parameter int MAX_Y           = 767,
   parameter int SAMPLE_CYCLES   = 500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [11:0] tgt_x,
   input  logic [11:0] tgt_y,
   input  logic [2:0]  btn,
   input  logic        ps2_clk_i,
   input  logic        ps2_data_i,
   output logic        ps2_clk_oe,
   output logic        ps2_data_oe,
   output logic [11:0] cur_x,
   output logic [11:0] cur_y,
   output logic        busy,
   output logic        pkt_done
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] GAP    = 3'd2;
   localparam logic [2:0] HI     = 3'd3;
   localparam logic [2:0] LO     = 3'd4;
   localparam logic [2:0] COMMIT = 3'd5;

   localparam int CNT_MAX = (IDLE_CYCLES > HALF_BIT_CYCLES) ? IDLE_CYCLES : HALF_BIT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT_CYCLES - 1);

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic [3:0]    bit_idx;
   logic [1:0]    byte_idx;
   logic [8:0]    lat_dx;
   logic [8:0]    lat_dy;
   logic [2:0]    lat_btn;
   logic [2:0]    last_btn;
   logic          clk_s1, clk_s2, dat_s1, dat_s2;
   logic          bus_idle;
   logic          rate_open;
   logic [11:0]   ex, ey;
   logic signed [12:0] dx_raw, dy_raw;
   logic [8:0]    dx_c, dy_c;
   logic          pending;
   logic [7:0]    cur_byte;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk_i;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data_i;
         dat_s2 <= dat_s1;
      end
   end

   assign bus_idle = clk_s2 & dat_s2;

   assign ex = (tgt_x > 12'(MAX_X)) ? 12'(MAX_X) : tgt_x;
   assign ey = (tgt_y > 12'(MAX_Y)) ? 12'(MAX_Y) : tgt_y;
   assign pending = (ex != cur_x) || (ey != cur_y) || (btn != last_btn);

   // PS/2 reports Y positive-up while our coordinates grow downwards.
   always_comb begin
      dx_raw = $signed({1'b0, ex}) - $signed({1'b0, cur_x});
      dy_raw = $signed({1'b0, cur_y}) - $signed({1'b0, ey});
      if (dx_raw > 13'sd255)       dx_c = 9'h0FF;
      else if (dx_raw < -13'sd255) dx_c = 9'h101;
      else                         dx_c = dx_raw[8:0];
      if (dy_raw > 13'sd255)       dy_c = 9'h0FF;
      else if (dy_raw < -13'sd255) dy_c = 9'h101;
      else                         dy_c = dy_raw[8:0];
   end

   always_comb begin
      case (byte_idx)
         2'd0:    cur_byte = {2'b00, lat_dy[8], lat_dx[8], 1'b1, lat_btn[1], lat_btn[0], lat_btn[2]};
         2'd1:    cur_byte = lat_dx[7:0];
         default: cur_byte = lat_dy[7:0];
      endcase
   end

   // Frame layout: start 0, D0..D7, odd parity, stop 1.
   function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
      logic [3:0] k;
      k = idx - 4'd1;
      if (idx == 4'd0)      frame_bit = 1'b0;
      else if (idx <= 4'd8) frame_bit = b[k[2:0]];
      else if (idx == 4'd9) frame_bit = ~^b;
      else                  frame_bit = 1'b1;
   endfunction

`ifdef PS2_DEV_RATE_LIMIT_EN
   localparam int RW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
   localparam logic [RW-1:0] RATE_LAST = RW'(SAMPLE_CYCLES - 1);
   logic [RW-1:0] rate_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                   rate_cnt <= RATE_LAST;
      else if (state == LOAD)      rate_cnt <= '0;
      else if (rate_cnt != RATE_LAST) rate_cnt <= rate_cnt + 1'b1;
   end

   assign rate_open = (rate_cnt == RATE_LAST);
`else
   assign rate_open = 1'b1;
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         byte_idx    <= '0;
         lat_dx      <= '0;
         lat_dy      <= '0;
         lat_btn     <= '0;
         last_btn    <= '0;
         cur_x       <= '0;
         cur_y       <= '0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         pkt_done    <= 1'b0;
      end else begin
         pkt_done <= 1'b0;
         case (state)
            IDLE: begin
               if (enable && pending && rate_open) state <= LOAD;
            end
            LOAD: begin
               lat_dx   <= dx_c;
               lat_dy   <= dy_c;
               lat_btn  <= btn;
               byte_idx <= 2'd0;
               cnt      <= '0;
               state    <= GAP;
            end
            GAP: begin
               if (!bus_idle) begin
                  cnt <= '0;
               end else if (cnt == IDLE_LAST) begin
                  cnt         <= '0;
                  bit_idx     <= 4'd0;
                  ps2_data_oe <= 1'b1;
                  state       <= HI;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HI: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  // A host holding the clock low inhibits us: drop the packet entirely.
                  if (!clk_s2) begin
                     ps2_data_oe <= 1'b0;
                     ps2_clk_oe  <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     ps2_clk_oe <= 1'b1;
                     state      <= LO;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            LO: begin
               if (cnt == HALF_LAST) begin
                  cnt        <= '0;
                  ps2_clk_oe <= 1'b0;
                  if (bit_idx != 4'd10) begin
                     bit_idx     <= bit_idx + 4'd1;
                     ps2_data_oe <= ~frame_bit(cur_byte, bit_idx + 4'd1);
                     state       <= HI;
                  end else if (byte_idx != 2'd2) begin
                     byte_idx    <= byte_idx + 2'd1;
                     ps2_data_oe <= 1'b0;
                     state       <= GAP;
                  end else begin
                     ps2_data_oe <= 1'b0;
                     state       <= COMMIT;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            COMMIT: begin
               cur_x    <= cur_x + {{3{lat_dx[8]}}, lat_dx};
               cur_y    <= cur_y - {{3{lat_dy[8]}}, lat_dy};
               last_btn <= lat_btn;
               pkt_done <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ps2_mouse_device_tx.sv
// Bench for ps2_mouse_device_tx: a host model decodes PS/2 frames and a position model predicts the packet stream.
module tb_ps2_mouse_device_tx;

   localparam int HALF = 8;
   localparam int IDLE = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b1;
   logic [11:0] tgt_x = '0;
   logic [11:0] tgt_y = '0;
   logic [2:0]  btn = '0;
   logic        host_hold = 1'b0;
   logic        ps2_clk_oe, ps2_data_oe, busy, pkt_done;
   logic [11:0] cur_x, cur_y;
   logic        bus_clk, bus_dat;

   assign bus_clk = ~(ps2_clk_oe | host_hold);
   assign bus_dat = ~ps2_data_oe;

   ps2_mouse_device_tx #(
      .HALF_BIT_CYCLES(HALF),
      .IDLE_CYCLES(IDLE),
      .MAX_X(1023),
      .MAX_Y(767),
      .SAMPLE_CYCLES(500000)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .tgt_x(tgt_x),
      .tgt_y(tgt_y),
      .btn(btn),
      .ps2_clk_i(bus_clk),
      .ps2_data_i(bus_dat),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .cur_x(cur_x),
      .cur_y(cur_y),
      .busy(busy),
      .pkt_done(pkt_done)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  rx_q[$];
   logic [7:0]  exp_q[$];
   int          rx_bits = 0;
   logic [10:0] rx_frame;
   int          done_cnt = 0;
   int          done0 = 0;
   int          exp_pk = 0;
   int          mx = 0;
   int          my = 0;
   logic [2:0]  mb = '0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
      end
   endtask

   // Host side: sample data on each falling edge of the bus clock.
   initial begin : host_decoder
      logic prev_clk;
      prev_clk = 1'b1;
      forever begin
         @(negedge clk);
         if (pkt_done) done_cnt++;
         if (prev_clk && !bus_clk) begin
            rx_frame[rx_bits] = bus_dat;
            rx_bits++;
            if (rx_bits == 11) begin
               checkOutput("start_bit", 32'(rx_frame[0]), 32'd0);
               checkOutput("parity_bit", 32'(rx_frame[9]), 32'(~^rx_frame[8:1]));
               checkOutput("stop_bit", 32'(rx_frame[10]), 32'd1);
               rx_q.push_back(rx_frame[8:1]);
               rx_bits = 0;
            end
         end
         prev_clk = bus_clk;
      end
   end

   function automatic int clamp255(input int v);
      if (v > 255) return 255;
      if (v < -255) return -255;
      return v;
   endfunction

   task automatic doReset();
      reset = 1'b1;
      tgt_x = '0;
      tgt_y = '0;
      btn = '0;
      host_hold = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      mx = 0;
      my = 0;
      mb = '0;
      rx_q.delete();
      rx_bits = 0;
   endtask

   // Predicts every packet needed to walk the reported position to the target.
   task automatic applyStimulus(input int tx, input int ty, input logic [2:0] b);
      int ex, ey, dx, dy;
      logic [7:0] b0;
      rx_q.delete();
      exp_q.delete();
      exp_pk = 0;
      done0 = done_cnt;
      ex = (tx > 1023) ? 1023 : tx;
      ey = (ty > 767) ? 767 : ty;
      while (ex != mx || ey != my || b != mb) begin
         dx = clamp255(ex - mx);
         dy = clamp255(my - ey);
         b0 = {2'b00, dy < 0, dx < 0, 1'b1, b[1], b[0], b[2]};
         exp_q.push_back(b0);
         exp_q.push_back(8'(dx & 255));
         exp_q.push_back(8'(dy & 255));
         mx = mx + dx;
         my = my - dy;
         mb = b;
         exp_pk++;
      end
      @(posedge clk);
      #1;
      tgt_x = 12'(tx);
      tgt_y = 12'(ty);
      btn = b;
   endtask

   task automatic waitAndVerify(input string tag);
      int waited = 0;
      int budget;
      budget = exp_pk * 900 + 200;
      while (waited < budget && !(rx_q.size() >= exp_q.size() && !busy && waited > 2)) begin
         @(posedge clk);
         #1;
         waited++;
      end
      checkOutput({tag, "_in_time"}, 32'(waited < budget), 32'd1);
      repeat (3 * IDLE) @(posedge clk);
      #1;
      checkOutput({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
      checkOutput({tag, "_pkts"}, 32'(done_cnt - done0), 32'(exp_pk));
      checkOutput({tag, "_cur_x"}, 32'(cur_x), 32'(mx));
      checkOutput({tag, "_cur_y"}, 32'(cur_y), 32'(my));
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin : watchdog
      #900000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin : main
      int w;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      checkOutput("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      checkOutput("rst_cur_x", 32'(cur_x), 32'd0);
      checkOutput("rst_cur_y", 32'(cur_y), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_pkt_done", 32'(pkt_done), 32'd0);
      doReset();

      applyStimulus(10, 0, 3'b000);
      waitAndVerify("x10");

      doReset();
      applyStimulus(600, 0, 3'b000);
      waitAndVerify("x600");

      doReset();
      applyStimulus(0, 5, 3'b000);
      waitAndVerify("y5");
      applyStimulus(0, 5, 3'b100);
      waitAndVerify("btn_l");
      applyStimulus(0, 5, 3'b000);
      waitAndVerify("btn_off");

      enable = 1'b0;
      applyStimulus(100, 100, 3'b010);
      repeat (200) @(posedge clk);
      #1;
      checkOutput("disabled_busy", 32'(busy), 32'd0);
      checkOutput("disabled_rx", 32'(rx_q.size()), 32'd0);
      enable = 1'b1;
      waitAndVerify("enabled");

      applyStimulus(2000, 2000, 3'b000);
      waitAndVerify("clamp");

      for (int i = 0; i < 6; i++) begin
         applyStimulus(int'($urandom_range(0, 1100)), int'($urandom_range(0, 850)), 3'($urandom));
         waitAndVerify($sformatf("rnd%0d", i));
      end

      doReset();
      applyStimulus(300, 40, 3'b001);
      w = 0;
      while (w < 3000 && !(rx_q.size() == 1 && rx_bits == 4)) begin
         @(posedge clk);
         #1;
         w++;
      end
      checkOutput("abort_reach_b1_bit4", 32'(w < 3000), 32'd1);
      host_hold = 1'b1;
      repeat (2 * HALF + 8) @(posedge clk);
      #1;
      checkOutput("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
      checkOutput("abort_data_oe", 32'(ps2_data_oe), 32'd0);
      checkOutput("abort_cur_x", 32'(cur_x), 32'd0);
      checkOutput("abort_cur_y", 32'(cur_y), 32'd0);
      checkOutput("abort_no_done", 32'(done_cnt - done0), 32'd0);
      repeat (40) @(posedge clk);
      #1;
      checkOutput("inhibit_hold_oe", 32'(ps2_clk_oe | ps2_data_oe), 32'd0);
      rx_q.delete();
      rx_bits = 0;
      host_hold = 1'b0;
      w = 0;
      while (w < 500 && !ps2_data_oe) begin
         @(posedge clk);
         #1;
         w++;
      end
      checkOutput("resend_after_idle", 32'(w >= IDLE && w < 500), 32'd1);
      waitAndVerify("resend");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
